// File: rtl/anode_scanner.sv
// anode_scanner: time-multiplexed one-hot anode driver for common-anode
// seven-segment banks. An internal prescaler defines digit slots, masked
// digits are skipped, and every slot opens with a blanking interval.
module anode_scanner #(
    parameter int unsigned DIGITS   = 8,
    parameter int unsigned PRESCALE = 100000,
    parameter int unsigned BLANK    = 16,
    localparam int unsigned IDXW    = (DIGITS > 1) ? $clog2(DIGITS) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [DIGITS-1:0] digit_mask,
    output logic [DIGITS-1:0] anode,
    output logic [IDXW-1:0]   digit_sel,
    output logic              slot_start
);

    localparam int unsigned CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(PRESCALE - 1);
    localparam logic [CW-1:0] CNT_BLANK = CW'(BLANK);

    logic [CW-1:0]     cnt_q, cnt_d;
    logic [IDXW-1:0]   idx_q, idx_d;
    logic [DIGITS-1:0] anode_q, anode_d;
    logic              slot_start_q, slot_start_d;

    logic [IDXW-1:0]   idx_next;
    logic              found;
    int unsigned       cand;

    // Next enabled digit after idx_q, searching upward with wrap-around;
    // the final candidate is idx_q itself so a lone enabled digit is reselected.
    always_comb begin
        idx_next = idx_q;
        found    = 1'b0;
        cand     = 0;
        for (int unsigned k = 1; k <= DIGITS; k++) begin
            cand = (32'(idx_q) + k) % DIGITS;
            if (!found && digit_mask[cand]) begin
                idx_next = IDXW'(cand);
                found    = 1'b1;
            end
        end
    end

    // Slot counter, index advance at wrap, and registered output decode.
    // Anode is decoded from the next-state cnt/idx so the registered output
    // lines up with the slot position it belongs to.
    always_comb begin
        cnt_d        = cnt_q;
        idx_d        = idx_q;
        slot_start_d = 1'b0;
        if (en) begin
            if (cnt_q == CNT_LAST) begin
                cnt_d        = '0;
                idx_d        = idx_next;
                slot_start_d = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
        anode_d = '1;
        if (en && (cnt_d >= CNT_BLANK) && digit_mask[idx_d]) begin
            anode_d = ~(DIGITS'(1) << idx_d);
        end
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q        <= '0;
            idx_q        <= '0;
            anode_q      <= '1;
            slot_start_q <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            anode_q      <= anode_d;
            slot_start_q <= slot_start_d;
        end
    end

    assign anode      = anode_q;
    assign digit_sel  = idx_q;
    assign slot_start = slot_start_q;

endmodule

// File: tb/tb_anode_scanner.sv
// Directed bench for anode_scanner with DIGITS=8, PRESCALE=4, BLANK=1.
module tb_anode_scanner;

    localparam int unsigned DIGITS   = 8;
    localparam int unsigned PRESCALE = 4;
    localparam int unsigned BLANK    = 1;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic [7:0] digit_mask = 8'hFF;
    logic [7:0] anode;
    logic [2:0] digit_sel;
    logic       slot_start;

    int checks = 0;
    int failures = 0;

    logic [7:0] exp_an;
    logic [2:0] exp_sel;
    logic       exp_ss;
    int         seq [3];

    anode_scanner #(
        .DIGITS(DIGITS),
        .PRESCALE(PRESCALE),
        .BLANK(BLANK)
    ) dut (
        .clk(clk),
        .rst(rst),
        .en(en),
        .digit_mask(digit_mask),
        .anode(anode),
        .digit_sel(digit_sel),
        .slot_start(slot_start)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [7:0] a, input logic [2:0] s, input logic ss);
        chk({tag, ".anode"}, 32'(anode), 32'(a));
        chk({tag, ".sel"}, 32'(digit_sel), 32'(s));
        chk({tag, ".slot_start"}, 32'(slot_start), 32'(ss));
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Asserts rst between edges, checks outputs before any clock edge, and
    // releases it just after the following edge.
    task automatic do_reset(input string tag);
        #2;
        rst = 1'b1;
        #1;
        chk_all(tag, 8'hFF, 3'd0, 1'b0);
        tick();
        rst = 1'b0;
    endtask

    initial begin
        seq[0] = 0; seq[1] = 2; seq[2] = 7;

        // Reset while running, then full scan with all digits enabled
        tick();
        do_reset("reset0");
        en = 1'b1;
        digit_mask = 8'hFF;
        for (int n = 1; n <= 36; n++) begin
            tick();
            exp_sel = 3'((n / 4) % 8);
            exp_ss  = (n % 4) == 0;
            exp_an  = exp_ss ? 8'hFF : ~(8'h01 << exp_sel);
            chk_all($sformatf("full_n%0d", n), exp_an, exp_sel, exp_ss);
        end

        // Asynchronous reset mid-slot
        tick();
        do_reset("reset_mid");

        // Mask skipping: 0 -> 2 -> 7 -> 0
        en = 1'b1;
        digit_mask = 8'b1000_0101;
        for (int n = 1; n <= 24; n++) begin
            tick();
            exp_sel = 3'(seq[(n / 4) % 3]);
            exp_ss  = (n % 4) == 0;
            exp_an  = exp_ss ? 8'hFF : ~(8'h01 << exp_sel);
            chk_all($sformatf("skip_n%0d", n), exp_an, exp_sel, exp_ss);
        end

        // Digit 0 masked after reset: first slot dark, then advance to 2
        do_reset("reset_m0");
        digit_mask = 8'h0C;
        for (int n = 1; n <= 3; n++) begin
            tick();
            chk_all($sformatf("dark0_n%0d", n), 8'hFF, 3'd0, 1'b0);
        end
        tick();
        chk_all("dark0_wrap", 8'hFF, 3'd2, 1'b1);
        tick();
        chk_all("dark0_drive", 8'hFB, 3'd2, 1'b0);

        // All masked: anodes dark, index holds, slot_start keeps pulsing
        do_reset("reset_m00");
        digit_mask = 8'h00;
        for (int n = 1; n <= 12; n++) begin
            tick();
            chk_all($sformatf("none_n%0d", n), 8'hFF, 3'd0, (n % 4) == 0);
        end

        // Freeze at cnt=2 of digit 3
        do_reset("reset_frz");
        digit_mask = 8'hFF;
        for (int n = 1; n <= 14; n++) tick();
        chk_all("frz_pre", 8'hF7, 3'd3, 1'b0);
        en = 1'b0;
        for (int n = 1; n <= 3; n++) begin
            tick();
            chk_all($sformatf("frz_hold%0d", n), 8'hFF, 3'd3, 1'b0);
        end
        en = 1'b1;
        tick();
        chk_all("frz_resume", 8'hF7, 3'd3, 1'b0);
        tick();
        chk_all("frz_wrap", 8'hFF, 3'd4, 1'b1);
        tick();
        chk_all("frz_next", 8'hEF, 3'd4, 1'b0);

        // Mid-slot mask clear of currently driven digit 5
        do_reset("reset_mm");
        digit_mask = 8'hFF;
        for (int n = 1; n <= 21; n++) tick();
        chk_all("mm_pre", 8'hDF, 3'd5, 1'b0);
        digit_mask = 8'hDF;
        tick();
        chk_all("mm_dark1", 8'hFF, 3'd5, 1'b0);
        tick();
        chk_all("mm_dark2", 8'hFF, 3'd5, 1'b0);
        tick();
        chk_all("mm_wrap", 8'hFF, 3'd6, 1'b1);
        tick();
        chk_all("mm_next", 8'hBF, 3'd6, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
